// File: rtl/otter_io_responder.sv
// OTTER MCU IOBUS responder: switch input port, LED register and an optional down-counting interrupt timer.
// Defining OTTER_IO_TIMER_EN builds the timer, its FSM, TSTAT and INTR; otherwise INTR is tied low.
module otter_io_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int unsigned SW_W      = 16,
    parameter int unsigned LED_W     = 16
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      IOBUS_IN,
    output logic             INTR,
    input  logic [SW_W-1:0]  SWITCHES,
    output logic [LED_W-1:0] LEDS
);

    localparam logic [7:0] OFF_SW     = 8'h00;
    localparam logic [7:0] OFF_LED    = 8'h20;
`ifdef OTTER_IO_TIMER_EN
    localparam logic [7:0] OFF_TCTRL  = 8'h40;
    localparam logic [7:0] OFF_TLOAD  = 8'h44;
    localparam logic [7:0] OFF_TCOUNT = 8'h48;
    localparam logic [7:0] OFF_TSTAT  = 8'h4C;
`endif

    logic             in_win;
    logic [7:0]       off;
    logic             wr_led;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      iobus_in_q, rdata_d;
    logic             unused_wdata;

    assign in_win       = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
    assign off          = IOBUS_ADDR[7:0];
    assign wr_led       = IOBUS_WR && in_win && (off == OFF_LED);
    assign led_d        = wr_led ? IOBUS_OUT[LED_W-1:0] : led_q;
    assign unused_wdata = ^IOBUS_OUT;

`ifdef OTTER_IO_TIMER_EN
    typedef enum logic {T_IDLE, T_RUN} tstate_e;

    tstate_e     state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;   // {IE, RELOAD, EN}
    logic [31:0] tload_q, tload_d, tcount_q, tcount_d;
    logic        pend_q, pend_d;
    logic        wr_tctrl, wr_tload, wr_tstat;

    assign wr_tctrl = IOBUS_WR && in_win && (off == OFF_TCTRL);
    assign wr_tload = IOBUS_WR && in_win && (off == OFF_TLOAD);
    assign wr_tstat = IOBUS_WR && in_win && (off == OFF_TSTAT);

    // Software effects first, then the FSM; expiry set overrides W1C, TLOAD write overrides the count.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        tload_d  = tload_q;
        tcount_d = tcount_q;
        pend_d   = pend_q;
        if (wr_tctrl) ctrl_d = IOBUS_OUT[2:0];
        if (wr_tstat && IOBUS_OUT[0]) pend_d = 1'b0;
        case (state_q)
            T_IDLE: if (ctrl_d[0]) state_d = T_RUN;
            T_RUN: begin
                if (!ctrl_d[0]) begin
                    state_d = T_IDLE;
                end else if (tcount_q == 32'd0) begin
                    pend_d = 1'b1;
                    if (ctrl_d[1]) begin
                        tcount_d = tload_q;
                    end else begin
                        ctrl_d[0] = 1'b0;
                        state_d   = T_IDLE;
                    end
                end else begin
                    tcount_d = tcount_q - 32'd1;
                end
            end
            default: state_d = T_IDLE;
        endcase
        if (wr_tload) begin
            tload_d  = IOBUS_OUT;
            tcount_d = IOBUS_OUT;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= T_IDLE;
            ctrl_q   <= '0;
            tload_q  <= '0;
            tcount_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            tload_q  <= tload_d;
            tcount_q <= tcount_d;
            pend_q   <= pend_d;
        end
    end

    assign INTR = pend_q & ctrl_q[2];
`else
    assign INTR = 1'b0;
`endif

    // Writable registers read back their next-state values; SW reads the settled synchronizer.
    always_comb begin
        rdata_d = '0;
        if (in_win) begin
            case (off)
                OFF_SW:     rdata_d = 32'(sw_sync_q);
                OFF_LED:    rdata_d = 32'(led_d);
`ifdef OTTER_IO_TIMER_EN
                OFF_TCTRL:  rdata_d = {29'd0, ctrl_d};
                OFF_TLOAD:  rdata_d = tload_d;
                OFF_TCOUNT: rdata_d = tcount_d;
                OFF_TSTAT:  rdata_d = {31'd0, pend_d};
`endif
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            led_q      <= '0;
            iobus_in_q <= '0;
        end else begin
            sw_meta_q  <= SWITCHES;
            sw_sync_q  <= sw_meta_q;
            led_q      <= led_d;
            iobus_in_q <= rdata_d;
        end
    end

    assign IOBUS_IN = iobus_in_q;
    assign LEDS     = led_q;

endmodule
